ifetch_ctrl: RTL and testbench

Parametrised instruction-fetch controller: the next generation of the single-word fetch sequencer. It drives PC → MAR → memory → MDR → IR control strobes for one or more instruction words per fetch, with a configurable address-setup length, a bounded MFC wait with timeout/error reporting, a PC increment strobe per word, and an explicit start/complete handshake to the execute sequencer. It sits between the execute control FSM and the datapath control lines of PC, MAR, memory, MDR and IR.

---
 rtl/ifetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: drives PC/MAR/memory/MDR/IR strobes for WORDS
// instruction words per request, with bounded MFC wait and error reporting.
module ifetch_ctrl #(
    parameter int WORDS       = 1,
    parameter int SETUP_CYC   = 2,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       done,
    input  logic       MFC,
    output logic       PC_Out,
    output logic       MAR_EN,
    output logic       mem_EN,
    output logic       mem_RW,
    output logic       MDR_EN_read,
    output logic       MDR_out,
    output logic       IR_EN,
    output logic       PC_INC,
    output logic [2:0] ir_word_sel,
    output logic       busy,
    output logic       fetch_done,
    output logic       err,
    output logic [3:0] state_dbg
);

    // Handshake: start is a level request honoured only in IDLE, DONE or ERR;
    // fetch_done is a one-cycle completion pulse; done aborts from any state.

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_REQ, S_WAIT, S_LATCH, S_XFER, S_LOAD, S_DONE, S_ERR
    } state_t;

    state_t     state, nxt_state;
    logic [2:0] word, nxt_word;
    logic [3:0] setup_cnt, nxt_setup;
    logic [7:0] wait_cnt, nxt_wait;

    assign state_dbg = state;

    always_comb begin
        nxt_state = state;
        nxt_word  = word;
        nxt_setup = setup_cnt;
        nxt_wait  = wait_cnt;
        if (done) begin
            nxt_state = S_IDLE;
            nxt_word  = '0;
            nxt_setup = '0;
            nxt_wait  = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        nxt_state = S_ADDR;
                        nxt_word  = '0;
                        nxt_setup = '0;
                    end else if (state == S_DONE) begin
                        nxt_state = S_IDLE;
                        nxt_word  = '0;
                    end
                end
                S_ADDR: begin
                    if (setup_cnt == 4'(SETUP_CYC - 1)) begin
                        nxt_state = S_REQ;
                        nxt_setup = '0;
                    end else begin
                        nxt_setup = setup_cnt + 4'd1;
                    end
                end
                S_REQ: begin
                    nxt_state = S_WAIT;
                    nxt_wait  = '0;
                end
                S_WAIT: begin
                    // MFC on the timeout edge still wins over the error path
                    if (MFC) begin
                        nxt_state = S_LATCH;
                    end else if (wait_cnt == 8'(MFC_TIMEOUT - 1)) begin
                        nxt_state = S_ERR;
                    end else begin
                        nxt_wait = wait_cnt + 8'd1;
                    end
                end
                S_LATCH: nxt_state = S_XFER;
                S_XFER:  nxt_state = S_LOAD;
                S_LOAD: begin
                    if (word == 3'(WORDS - 1)) begin
                        nxt_state = S_DONE;
                    end else begin
                        nxt_state = S_ADDR;
                        nxt_word  = word + 3'd1;
                        nxt_setup = '0;
                    end
                end
                default: begin
                    nxt_state = S_IDLE;
                    nxt_word  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered with it, so they
    // always match the state register without any input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            word        <= '0;
            setup_cnt   <= '0;
            wait_cnt    <= '0;
            PC_Out      <= 1'b0;
            MAR_EN      <= 1'b0;
            mem_EN      <= 1'b0;
            mem_RW      <= 1'b0;
            MDR_EN_read <= 1'b0;
            MDR_out     <= 1'b0;
            IR_EN       <= 1'b0;
            PC_INC      <= 1'b0;
            ir_word_sel <= '0;
            busy        <= 1'b0;
            fetch_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= nxt_state;
            word        <= nxt_word;
            setup_cnt   <= nxt_setup;
            wait_cnt    <= nxt_wait;
            PC_Out      <= (nxt_state == S_ADDR);
            MAR_EN      <= (nxt_state == S_ADDR) && (nxt_setup == 4'(SETUP_CYC - 1));
            mem_EN      <= nxt_state inside {S_REQ, S_WAIT, S_LATCH};
            mem_RW      <= nxt_state inside {S_WAIT, S_LATCH, S_XFER, S_LOAD};
            MDR_EN_read <= (nxt_state == S_LATCH);
            MDR_out     <= nxt_state inside {S_XFER, S_LOAD};
            IR_EN       <= (nxt_state == S_LOAD);
            PC_INC      <= (nxt_state == S_LOAD);
            ir_word_sel <= (nxt_state == S_IDLE) ? 3'd0 : nxt_word;
            busy        <= !(nxt_state inside {S_IDLE, S_DONE, S_ERR});
            fetch_done  <= (nxt_state == S_DONE);
            err         <= (nxt_state == S_ERR);
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: two configurations driven from a table of per-cycle
// vectors, plus a hand-written asynchronous reset sequence.
module tb_ifetch_ctrl;

    localparam int S_IDLE = 0, S_ADDR = 1, S_REQ = 2, S_WAIT = 3, S_LATCH = 4,
                   S_XFER = 5, S_LOAD = 6, S_DONE = 7, S_ERR = 8;
    localparam int W = 14;

    typedef struct {
        int   sel;
        logic start;
        logic done;
        logic mfc;
        int   st;
        int   word;
        logic mar;
    } vec_t;

    logic clk, rst;
    logic start_a, done_a, mfc_a, start_b, done_b, mfc_b;
    logic pc_a, mar_a, men_a, mrw_a, mdrr_a, mdro_a, ir_a, inc_a, busy_a, fd_a, err_a;
    logic pc_b, mar_b, men_b, mrw_b, mdrr_b, mdro_b, ir_b, inc_b, busy_b, fd_b, err_b;
    logic [2:0] sel_a, sel_b;
    logic [3:0] dbg_a, dbg_b;
    logic [W-1:0] out_a, out_b;
    logic [W-1:0] exp_q[$];
    vec_t tbl[$];
    int total_cnt = 0;
    int pass_cnt = 0;

    ifetch_ctrl #(.WORDS(1), .SETUP_CYC(2), .MFC_TIMEOUT(15)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .done(done_a), .MFC(mfc_a),
        .PC_Out(pc_a), .MAR_EN(mar_a), .mem_EN(men_a), .mem_RW(mrw_a),
        .MDR_EN_read(mdrr_a), .MDR_out(mdro_a), .IR_EN(ir_a), .PC_INC(inc_a),
        .ir_word_sel(sel_a), .busy(busy_a), .fetch_done(fd_a), .err(err_a),
        .state_dbg(dbg_a)
    );

    ifetch_ctrl #(.WORDS(4), .SETUP_CYC(1), .MFC_TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .done(done_b), .MFC(mfc_b),
        .PC_Out(pc_b), .MAR_EN(mar_b), .mem_EN(men_b), .mem_RW(mrw_b),
        .MDR_EN_read(mdrr_b), .MDR_out(mdro_b), .IR_EN(ir_b), .PC_INC(inc_b),
        .ir_word_sel(sel_b), .busy(busy_b), .fetch_done(fd_b), .err(err_b),
        .state_dbg(dbg_b)
    );

    assign out_a = {pc_a, mar_a, men_a, mrw_a, mdrr_a, mdro_a, ir_a, inc_a,
                    sel_a, busy_a, fd_a, err_a};
    assign out_b = {pc_b, mar_b, men_b, mrw_b, mdrr_b, mdro_b, ir_b, inc_b,
                    sel_b, busy_b, fd_b, err_b};

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected strobe vector for a state, straight from the output table.
    function automatic logic [W-1:0] exp_out(int st, int word, logic mar);
        logic [W-1:0] v;
        v = '0;
        case (st)
            S_ADDR:  begin v[13] = 1'b1; v[12] = mar; end
            S_REQ:   v[11] = 1'b1;
            S_WAIT:  begin v[11] = 1'b1; v[10] = 1'b1; end
            S_LATCH: begin v[11] = 1'b1; v[10] = 1'b1; v[9] = 1'b1; end
            S_XFER:  begin v[10] = 1'b1; v[8] = 1'b1; end
            S_LOAD:  begin v[10] = 1'b1; v[8] = 1'b1; v[7] = 1'b1; v[6] = 1'b1; end
            S_DONE:  v[1] = 1'b1;
            S_ERR:   v[0] = 1'b1;
            default: v = '0;
        endcase
        if (st != S_IDLE) v[5:3] = 3'(word);
        if (st >= S_ADDR && st <= S_LOAD) v[2] = 1'b1;
        return v;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // driver: apply one cycle of inputs, push expectation, compare after the edge
    task automatic step(int sel, logic s, logic d, logic m, logic [W-1:0] e, string name);
        logic [W-1:0] act;
        start_a = (sel == 0) ? s : 1'b0;
        done_a  = (sel == 0) ? d : 1'b0;
        mfc_a   = (sel == 0) ? m : 1'b0;
        start_b = (sel == 1) ? s : 1'b0;
        done_b  = (sel == 1) ? d : 1'b0;
        mfc_b   = (sel == 1) ? m : 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        act = (sel == 0) ? out_a : out_b;
        check(name, act, exp_q.pop_front());
    endtask

    task automatic add(int sel, logic s, logic d, logic m, int st, int word, logic mar);
        vec_t v;
        v.sel = sel; v.start = s; v.done = d; v.mfc = m;
        v.st = st; v.word = word; v.mar = mar;
        tbl.push_back(v);
    endtask

    // One word: ADDR x setup, REQ, WAIT x (1+delay), LATCH, XFER, LOAD.
    task automatic add_word(int sel, int setup, int word, int delay, logic hold);
        for (int i = 0; i < setup; i++)
            add(sel, (word == 0 && i == 0) ? 1'b1 : hold, 1'b0, 1'b1, S_ADDR, word, i == setup - 1);
        add(sel, hold, 1'b0, 1'b1, S_REQ, word, 1'b0);
        add(sel, hold, 1'b0, delay == 0, S_WAIT, word, 1'b0);
        for (int i = 0; i < delay; i++)
            add(sel, hold, 1'b0, 1'b0, S_WAIT, word, 1'b0);
        add(sel, hold, 1'b0, 1'b1, S_LATCH, word, 1'b0);
        add(sel, hold, 1'b0, 1'b1, S_XFER, word, 1'b0);
        add(sel, hold, 1'b0, 1'b1, S_LOAD, word, 1'b0);
    endtask

    task automatic add_fetch(int sel, int setup, int words, int delay, logic hold);
        for (int w = 0; w < words; w++) add_word(sel, setup, w, delay, hold);
        add(sel, hold, 1'b0, 1'b1, S_DONE, words - 1, 1'b0);
    endtask

    initial begin
        start_a = 0; done_a = 0; mfc_a = 0;
        start_b = 0; done_b = 0; mfc_b = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        check("reset_a", out_a, '0);
        check("reset_b", out_b, '0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;

        // config A: defaults, MFC high throughout, fetch_done in cycle 8
        add_fetch(0, 2, 1, 0, 1'b0);
        add(0, 0, 0, 1, S_IDLE, 0, 0);
        add(0, 0, 0, 1, S_IDLE, 0, 0);
        // start held high: back-to-back fetches, start ignored while busy
        add_fetch(0, 2, 1, 0, 1'b1);
        add_fetch(0, 2, 1, 0, 1'b1);
        add_fetch(0, 2, 1, 0, 1'b1);
        add(0, 0, 0, 1, S_IDLE, 0, 0);
        // done in ADDR, then done beating start in DONE
        add(0, 1, 0, 1, S_ADDR, 0, 0);
        add(0, 1, 1, 1, S_IDLE, 0, 0);
        add(0, 0, 0, 0, S_IDLE, 0, 0);
        add_fetch(0, 2, 1, 0, 1'b0);
        add(0, 1, 1, 1, S_IDLE, 0, 0);
        add(0, 0, 0, 0, S_IDLE, 0, 0);

        // config B: 4 words, MFC two cycles late each word (rises on timeout edge)
        add_fetch(1, 1, 4, 2, 1'b0);
        add(1, 0, 0, 0, S_IDLE, 0, 0);
        // timeout on word 0, MFC in ERR ignored, restart from ERR
        add(1, 1, 0, 0, S_ADDR, 0, 1);
        add(1, 0, 0, 0, S_REQ, 0, 0);
        add(1, 0, 0, 0, S_WAIT, 0, 0);
        add(1, 0, 0, 0, S_WAIT, 0, 0);
        add(1, 0, 0, 0, S_WAIT, 0, 0);
        add(1, 0, 0, 0, S_ERR, 0, 0);
        add(1, 0, 0, 1, S_ERR, 0, 0);
        add(1, 0, 0, 0, S_ERR, 0, 0);
        add_fetch(1, 1, 4, 0, 1'b0);
        add(1, 0, 0, 0, S_IDLE, 0, 0);
        // timeout on word 1, done leaves ERR
        add_word(1, 1, 0, 0, 1'b0);
        add(1, 0, 0, 0, S_ADDR, 1, 1);
        add(1, 0, 0, 0, S_REQ, 1, 0);
        add(1, 0, 0, 0, S_WAIT, 1, 0);
        add(1, 0, 0, 0, S_WAIT, 1, 0);
        add(1, 0, 0, 0, S_WAIT, 1, 0);
        add(1, 0, 0, 0, S_ERR, 1, 0);
        add(1, 0, 0, 0, S_ERR, 1, 0);
        add(1, 0, 1, 0, S_IDLE, 0, 0);
        add(1, 0, 0, 0, S_IDLE, 0, 0);
        // done in WAIT of the second word beats a simultaneous MFC
        add_word(1, 1, 0, 0, 1'b0);
        add(1, 0, 0, 0, S_ADDR, 1, 1);
        add(1, 0, 0, 0, S_REQ, 1, 0);
        add(1, 0, 0, 0, S_WAIT, 1, 0);
        add(1, 0, 1, 1, S_IDLE, 0, 0);
        add(1, 0, 0, 1, S_IDLE, 0, 0);
        // done together with start in DONE
        add_fetch(1, 1, 4, 0, 1'b0);
        add(1, 1, 1, 0, S_IDLE, 0, 0);
        add(1, 0, 0, 0, S_IDLE, 0, 0);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].sel, tbl[i].start, tbl[i].done, tbl[i].mfc,
                 exp_out(tbl[i].st, tbl[i].word, tbl[i].mar), $sformatf("vec%0d", i));

        // asynchronous reset while in LATCH clears outputs before the next edge
        step(0, 1, 0, 1, exp_out(S_ADDR, 0, 0), "rst_seq_addr0");
        step(0, 0, 0, 1, exp_out(S_ADDR, 0, 1), "rst_seq_addr1");
        step(0, 0, 0, 1, exp_out(S_REQ, 0, 0), "rst_seq_req");
        step(0, 0, 0, 1, exp_out(S_WAIT, 0, 0), "rst_seq_wait");
        step(0, 0, 0, 1, exp_out(S_LATCH, 0, 0), "rst_seq_latch");
        #2 rst = 1'b0;
        #1;
        check("async_rst_outputs", out_a, '0);
        check("async_rst_state", {10'b0, dbg_a}, '0);
        @(posedge clk);
        #3 rst = 1'b1;
        step(0, 0, 0, 1, exp_out(S_IDLE, 0, 0), "post_rst_idle0");
        step(0, 0, 0, 1, exp_out(S_IDLE, 0, 0), "post_rst_idle1");
        step(0, 0, 0, 0, exp_out(S_IDLE, 0, 0), "post_rst_idle2");

        // report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
